// File: rtl/store_queue_fwd.sv
// In-order store queue: allocate at dispatch, fill at execute, commit on retire, drain via req/ack,
// forward to younger loads. Define SQ_PERF_CNT_EN to add saturating forwarding/stall/full counters.
module store_queue_fwd #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int SQ_DEPTH   = 8,
    localparam int IDW  = $clog2(SQ_DEPTH),
    localparam int PW   = IDW + 1,
    localparam int NB   = DATA_WIDTH / 8,
    localparam int OFFW = $clog2(NB)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  alloc_valid,
    output logic                  alloc_ready,
    output logic [PW-1:0]         alloc_id,
    input  logic                  exe_valid,
    input  logic [PW-1:0]         exe_id,
    input  logic [ADDR_WIDTH-1:0] exe_addr,
    input  logic [DATA_WIDTH-1:0] exe_data,
    input  logic [2:0]            exe_funct3,
    input  logic                  commit_valid,
    input  logic                  flush,
    input  logic                  ld_valid,
    input  logic [ADDR_WIDTH-1:0] ld_addr,
    input  logic [2:0]            ld_funct3,
    input  logic [PW-1:0]         ld_sq_tail,
    output logic                  fwd_hit,
    output logic [DATA_WIDTH-1:0] fwd_data,
    output logic                  fwd_stall,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [NB-1:0]         mem_wstrb,
    input  logic                  mem_ack,
    output logic                  empty
`ifdef SQ_PERF_CNT_EN
    ,
    output logic [31:0]           perf_fwd_cnt,
    output logic [31:0]           perf_stall_cnt,
    output logic [31:0]           perf_full_cnt
`endif
);

    typedef enum logic {IDLE, REQ} drain_state_t;

    function automatic logic [NB-1:0] lane_strb(input logic [1:0] size, input logic [OFFW-1:0] off);
        case (size)
            2'd0:    lane_strb = NB'(1) << off;
            2'd1:    lane_strb = NB'(3) << off;
            default: lane_strb = '1;
        endcase
    endfunction

    function automatic logic [DATA_WIDTH-1:0] lane_data(input logic [1:0] size, input logic [OFFW-1:0] off,
                                                        input logic [DATA_WIDTH-1:0] d);
        case (size)
            2'd0:    lane_data = (d & DATA_WIDTH'(8'hFF)) << {off, 3'b000};
            2'd1:    lane_data = (d & DATA_WIDTH'(16'hFFFF)) << {off, 3'b000};
            default: lane_data = d;
        endcase
    endfunction

    logic [PW-1:0]         head, cmt, tail;
    logic [IDW-1:0]        head_idx, cmt_idx, tail_idx, exe_idx;
    logic [SQ_DEPTH-1:0]   ent_valid, ent_addr_ok, ent_cmt, squash;
    logic [ADDR_WIDTH-1:0] ent_addr [SQ_DEPTH];
    logic [DATA_WIDTH-1:0] ent_data [SQ_DEPTH];
    logic [NB-1:0]         ent_strb [SQ_DEPTH];
    drain_state_t          state, state_next;
    logic                  full, alloc_fire, commit_fire, drain_done;

    assign head_idx    = head[IDW-1:0];
    assign cmt_idx     = cmt[IDW-1:0];
    assign tail_idx    = tail[IDW-1:0];
    assign exe_idx     = exe_id[IDW-1:0];
    assign full        = (tail ^ head) == {1'b1, {IDW{1'b0}}};
    assign empty       = (tail == head);
    assign alloc_ready = !full;
    assign alloc_id    = tail;
    assign alloc_fire  = alloc_valid && !full && !flush;
    assign commit_fire = commit_valid && (cmt != tail) && !flush;
    assign drain_done  = (state == REQ) && mem_ack;

    // Entries in [cmt, tail) are the uncommitted ones a flush discards.
    always_comb begin
        for (int i = 0; i < SQ_DEPTH; i++)
            squash[i] = {1'b0, IDW'(i) - cmt_idx} < (tail - cmt);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head        <= '0;
            cmt         <= '0;
            tail        <= '0;
            ent_valid   <= '0;
            ent_addr_ok <= '0;
            ent_cmt     <= '0;
            for (int i = 0; i < SQ_DEPTH; i++) begin
                ent_addr[i] <= '0;
                ent_data[i] <= '0;
                ent_strb[i] <= '0;
            end
        end else begin
            if (drain_done) begin
                ent_valid[head_idx] <= 1'b0;
                ent_cmt[head_idx]   <= 1'b0;
                head                <= head + 1'b1;
            end
            if (flush) begin
                tail <= cmt;
                for (int i = 0; i < SQ_DEPTH; i++) begin
                    if (squash[i]) begin
                        ent_valid[i]   <= 1'b0;
                        ent_addr_ok[i] <= 1'b0;
                    end
                end
            end else begin
                if (alloc_fire) begin
                    ent_valid[tail_idx]   <= 1'b1;
                    ent_addr_ok[tail_idx] <= 1'b0;
                    ent_cmt[tail_idx]     <= 1'b0;
                    tail                  <= tail + 1'b1;
                end
                if (exe_valid) begin
                    ent_addr[exe_idx]    <= exe_addr;
                    ent_data[exe_idx]    <= lane_data(exe_funct3[1:0], exe_addr[OFFW-1:0], exe_data);
                    ent_strb[exe_idx]    <= lane_strb(exe_funct3[1:0], exe_addr[OFFW-1:0]);
                    ent_addr_ok[exe_idx] <= 1'b1;
                end
                if (commit_fire) begin
                    ent_cmt[cmt_idx] <= 1'b1;
                    cmt              <= cmt + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Drain outputs come straight from the head entry, which cannot change while it is in REQ.
    always_comb begin
        state_next = state;
        mem_req    = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        mem_wstrb  = '0;
        case (state)
            IDLE: if (ent_valid[head_idx] && ent_cmt[head_idx] && ent_addr_ok[head_idx]) state_next = REQ;
            REQ: begin
                mem_req   = 1'b1;
                mem_addr  = ent_addr[head_idx];
                mem_wdata = ent_data[head_idx];
                mem_wstrb = ent_strb[head_idx];
                if (mem_ack) state_next = IDLE;
            end
        endcase
    end

    logic [NB-1:0]  ld_strb, overlap;
    logic [PW-1:0]  older, scan_id;
    logic [IDW-1:0] scan_idx;
    logic           scan_done;

    // Youngest-first scan of stores older than the load; the first relevant entry decides.
    always_comb begin
        fwd_hit   = 1'b0;
        fwd_stall = 1'b0;
        fwd_data  = '0;
        scan_done = 1'b0;
        scan_id   = '0;
        scan_idx  = '0;
        overlap   = '0;
        ld_strb   = lane_strb(ld_funct3[1:0], ld_addr[OFFW-1:0]);
        older     = ld_sq_tail - head;
        if (ld_valid && older <= PW'(SQ_DEPTH)) begin
            for (int i = 0; i < SQ_DEPTH; i++) begin
                scan_id  = ld_sq_tail - PW'(i + 1);
                scan_idx = scan_id[IDW-1:0];
                overlap  = ent_strb[scan_idx] & ld_strb;
                if (!scan_done && PW'(i) < older && ent_valid[scan_idx]) begin
                    if (!ent_addr_ok[scan_idx]) begin
                        fwd_stall = 1'b1;
                        scan_done = 1'b1;
                    end else if (ent_addr[scan_idx][ADDR_WIDTH-1:OFFW] == ld_addr[ADDR_WIDTH-1:OFFW]
                                 && |overlap) begin
                        scan_done = 1'b1;
                        if (overlap == ld_strb) begin
                            fwd_hit  = 1'b1;
                            fwd_data = ent_data[scan_idx];
                        end else begin
                            fwd_stall = 1'b1;
                        end
                    end
                end
            end
        end
    end

`ifdef SQ_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fwd_cnt   <= '0;
            perf_stall_cnt <= '0;
            perf_full_cnt  <= '0;
        end else begin
            if (fwd_hit && perf_fwd_cnt != '1)                   perf_fwd_cnt   <= perf_fwd_cnt + 1'b1;
            if (fwd_stall && perf_stall_cnt != '1)               perf_stall_cnt <= perf_stall_cnt + 1'b1;
            if (alloc_valid && full && perf_full_cnt != '1)      perf_full_cnt  <= perf_full_cnt + 1'b1;
        end
    end
`endif

`ifndef SYNTHESIS
    commit_needs_entry: assert property (@(posedge clk) disable iff (!rst_n)
        (commit_valid && !flush) |-> (cmt != tail));
`endif

endmodule

// File: tb/tb_store_queue_fwd.sv
// Scoreboard bench for store_queue_fwd: expected forwarding and drain transactions are queued by the
// stimulus and popped by a monitor whenever the DUT presents a load result or a memory request.
module tb_store_queue_fwd;

    localparam int PW = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        alloc_valid, alloc_ready;
    logic [3:0]  alloc_id;
    logic        exe_valid;
    logic [3:0]  exe_id;
    logic [31:0] exe_addr, exe_data;
    logic [2:0]  exe_funct3;
    logic        commit_valid, flush;
    logic        ld_valid;
    logic [31:0] ld_addr;
    logic [2:0]  ld_funct3;
    logic [3:0]  ld_sq_tail;
    logic        fwd_hit, fwd_stall;
    logic [31:0] fwd_data;
    logic        mem_req, mem_ack;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        empty;
`ifdef SQ_PERF_CNT_EN
    logic [31:0] perf_fwd_cnt, perf_stall_cnt, perf_full_cnt;
`endif

    store_queue_fwd dut (
        .clk(clk), .rst_n(rst_n),
        .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_id(alloc_id),
        .exe_valid(exe_valid), .exe_id(exe_id), .exe_addr(exe_addr), .exe_data(exe_data),
        .exe_funct3(exe_funct3), .commit_valid(commit_valid), .flush(flush),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_funct3(ld_funct3), .ld_sq_tail(ld_sq_tail),
        .fwd_hit(fwd_hit), .fwd_data(fwd_data), .fwd_stall(fwd_stall),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_ack(mem_ack), .empty(empty)
`ifdef SQ_PERF_CNT_EN
        , .perf_fwd_cnt(perf_fwd_cnt), .perf_stall_cnt(perf_stall_cnt), .perf_full_cnt(perf_full_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed { logic hit; logic stall; logic [31:0] data; } fwd_exp_t;
    typedef struct packed { logic [31:0] addr; logic [31:0] wdata; logic [3:0] wstrb; } mem_exp_t;

    fwd_exp_t fwd_q[$];
    mem_exp_t mem_q[$];
    int       n_checks = 0;
    int       n_fail   = 0;
    int       ack_delay = 0;
    int       req_cycles = 0;
    bit       in_txn = 1'b0;
    mem_exp_t cur;
    fwd_exp_t fe;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic a, input logic e, input logic [3:0] id,
                                 input logic [31:0] addr, input logic [31:0] data, input logic [2:0] f3,
                                 input logic c, input logic fl);
        alloc_valid  = a;
        exe_valid    = e;
        exe_id       = id;
        exe_addr     = addr;
        exe_data     = data;
        exe_funct3   = f3;
        commit_valid = c;
        flush        = fl;
        tick();
        alloc_valid  = 1'b0;
        exe_valid    = 1'b0;
        commit_valid = 1'b0;
        flush        = 1'b0;
        ld_valid     = 1'b0;
    endtask

    task automatic idle();
        applyStimulus(0, 0, 4'd0, 32'd0, 32'd0, 3'd0, 0, 0);
    endtask

    task automatic alloc();
        applyStimulus(1, 0, 4'd0, 32'd0, 32'd0, 3'd0, 0, 0);
    endtask

    task automatic exec(input logic [3:0] id, input logic [31:0] addr, input logic [31:0] data,
                        input logic [2:0] f3);
        applyStimulus(0, 1, id, addr, data, f3, 0, 0);
    endtask

    task automatic flushQ();
        applyStimulus(0, 0, 4'd0, 32'd0, 32'd0, 3'd0, 0, 1);
    endtask

    task automatic commitStore(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb);
        mem_exp_t m;
        m.addr  = addr;
        m.wdata = wdata;
        m.wstrb = wstrb;
        mem_q.push_back(m);
        applyStimulus(0, 0, 4'd0, 32'd0, 32'd0, 3'd0, 1, 0);
    endtask

    task automatic loadCheck(input logic [31:0] addr, input logic [2:0] f3, input logic [3:0] tl,
                             input logic h, input logic s, input logic [31:0] d);
        fwd_exp_t x;
        x.hit   = h;
        x.stall = s;
        x.data  = d;
        fwd_q.push_back(x);
        ld_valid   = 1'b1;
        ld_addr    = addr;
        ld_funct3  = f3;
        ld_sq_tail = tl;
        idle();
    endtask

    task automatic waitEmpty(input int budget);
        int n = 0;
        while (!empty && n < budget) begin
            tick();
            n++;
        end
        checkOutput("drain_empty", 32'(empty), 1);
    endtask

    // Memory model: acknowledges a request after ack_delay cycles of unacknowledged mem_req.
    initial begin
        mem_ack = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (mem_ack || !mem_req) begin
                mem_ack    = 1'b0;
                req_cycles = 0;
            end else if (req_cycles >= ack_delay) begin
                mem_ack = 1'b1;
            end else begin
                req_cycles++;
            end
        end
    end

    // Monitor: compares load results and drain transactions against the scoreboard queues.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) in_txn = 1'b0;
            if (ld_valid) begin
                if (fwd_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("[TB] FAIL fwd_unexpected: got a load lookup, expected none");
                end else begin
                    fe = fwd_q.pop_front();
                    checkOutput("fwd_hit", 32'(fwd_hit), 32'(fe.hit));
                    checkOutput("fwd_stall", 32'(fwd_stall), 32'(fe.stall));
                    checkOutput("fwd_data", fwd_data, fe.data);
                end
            end else begin
                checkOutput("fwd_idle", 32'({fwd_hit, fwd_stall, fwd_data != 32'd0}), 0);
            end
            if (mem_req) begin
                if (!in_txn) begin
                    if (mem_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("[TB] FAIL mem_unexpected: got mem_req addr 0x%0h, expected none", mem_addr);
                    end else begin
                        cur    = mem_q.pop_front();
                        in_txn = 1'b1;
                        checkOutput("mem_addr", mem_addr, cur.addr);
                        checkOutput("mem_wdata", mem_wdata, cur.wdata);
                        checkOutput("mem_wstrb", 32'(mem_wstrb), 32'(cur.wstrb));
                    end
                end else begin
                    checkOutput("mem_hold_addr", mem_addr, cur.addr);
                    checkOutput("mem_hold_wdata", mem_wdata, cur.wdata);
                    checkOutput("mem_hold_wstrb", 32'(mem_wstrb), 32'(cur.wstrb));
                end
                if (mem_ack) in_txn = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    logic [3:0]  id;
    logic [31:0] a_cur, d_cur, a_prev, d_prev;
    int          n;

    initial begin
        rst_n = 1'b0;
        alloc_valid = 1'b0; exe_valid = 1'b0; exe_id = '0; exe_addr = '0; exe_data = '0; exe_funct3 = '0;
        commit_valid = 1'b0; flush = 1'b0; ld_valid = 1'b0; ld_addr = '0; ld_funct3 = '0; ld_sq_tail = '0;
        #2;
        checkOutput("rst_alloc_ready", 32'(alloc_ready), 1);
        checkOutput("rst_empty", 32'(empty), 1);
        checkOutput("rst_alloc_id", 32'(alloc_id), 0);
        checkOutput("rst_mem_req", 32'(mem_req), 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        $display("[TB] fill");
        for (int i = 0; i < 8; i++) begin
            checkOutput("alloc_id_fill", 32'(alloc_id), 32'(i));
            alloc();
        end
        checkOutput("alloc_ready_full", 32'(alloc_ready), 0);
        checkOutput("empty_full", 32'(empty), 0);
        alloc();
        checkOutput("alloc_id_after_full", 32'(alloc_id), 8);
        checkOutput("alloc_ready_still_full", 32'(alloc_ready), 0);
        flushQ();
        checkOutput("empty_after_flush", 32'(empty), 1);
        checkOutput("alloc_id_after_flush", 32'(alloc_id), 0);

        $display("[TB] SW forward and slow drain");
        ack_delay = 3;
        alloc();
        exec(4'd0, 32'h100, 32'hDEADBEEF, 3'd2);
        commitStore(32'h100, 32'hDEADBEEF, 4'hF);
        loadCheck(32'h100, 3'd2, 4'd1, 1, 0, 32'hDEADBEEF);
        waitEmpty(20);

        $display("[TB] SB partial overlap");
        ack_delay = 0;
        alloc();
        exec(4'd1, 32'h103, 32'h123456AA, 3'd0);
        loadCheck(32'h100, 3'd2, 4'd2, 0, 1, 32'h0);
        loadCheck(32'h103, 3'd0, 4'd2, 1, 0, 32'hAA000000);
        loadCheck(32'h102, 3'd0, 4'd2, 0, 0, 32'h0);
        loadCheck(32'h103, 3'd0, 4'd1, 0, 0, 32'h0);
        commitStore(32'h103, 32'hAA000000, 4'h8);
        waitEmpty(10);

        $display("[TB] unknown older address");
        ack_delay = 1;
        alloc();
        alloc();
        exec(4'd3, 32'h200, 32'h11223344, 3'd2);
        loadCheck(32'h300, 3'd2, 4'd4, 0, 1, 32'h0);
        loadCheck(32'h200, 3'd2, 4'd4, 1, 0, 32'h11223344);
        exec(4'd2, 32'h204, 32'h55667788, 3'd2);
        loadCheck(32'h300, 3'd2, 4'd4, 0, 0, 32'h0);
        loadCheck(32'h204, 3'd2, 4'd4, 1, 0, 32'h55667788);
        loadCheck(32'h206, 3'd1, 4'd4, 1, 0, 32'h55667788);
        commitStore(32'h204, 32'h55667788, 4'hF);
        commitStore(32'h200, 32'h11223344, 4'hF);
        waitEmpty(20);

        $display("[TB] flush with committed entries");
        ack_delay = 5;
        for (int i = 0; i < 4; i++) alloc();
        exec(4'd4, 32'h400, 32'hA0A0A0A0, 3'd2);
        exec(4'd5, 32'h404, 32'hA1A1A1A1, 3'd2);
        exec(4'd6, 32'h408, 32'hA2A2A2A2, 3'd2);
        exec(4'd7, 32'h40C, 32'hA3A3A3A3, 3'd2);
        loadCheck(32'h408, 3'd2, 4'd8, 1, 0, 32'hA2A2A2A2);
        commitStore(32'h400, 32'hA0A0A0A0, 4'hF);
        commitStore(32'h404, 32'hA1A1A1A1, 4'hF);
        flushQ();
        checkOutput("alloc_id_after_flush2", 32'(alloc_id), 6);
        loadCheck(32'h408, 3'd2, 4'd8, 0, 0, 32'h0);
        loadCheck(32'h40C, 3'd2, 4'd8, 0, 0, 32'h0);
        checkOutput("not_empty_during_drain", 32'(empty), 0);
        waitEmpty(40);

        $display("[TB] wrap-around");
        ack_delay = 0;
        a_prev = '0;
        d_prev = '0;
        for (int k = 0; k < 20; k++) begin
            id    = 4'(6 + k);
            a_cur = 32'h800 + 32'(k) * 32'd4;
            d_cur = 32'h10000000 + 32'(k) * 32'h0101;
            checkOutput("alloc_id_wrap", 32'(alloc_id), 32'(id));
            alloc();
            exec(id, a_cur, d_cur, 3'd2);
            if (k > 0) begin
                loadCheck(a_prev, 3'd2, id + 4'd1, 1, 0, d_prev);
                commitStore(a_prev, d_prev, 4'hF);
            end
            loadCheck(a_cur, 3'd2, id + 4'd1, 1, 0, d_cur);
            a_prev = a_cur;
            d_prev = d_cur;
        end
        commitStore(a_prev, d_prev, 4'hF);
        waitEmpty(20);
        checkOutput("alloc_id_end_wrap", 32'(alloc_id), 10);

        $display("[TB] reset during drain");
        ack_delay = 40;
        alloc();
        exec(4'd10, 32'h900, 32'hCAFEF00D, 3'd2);
        commitStore(32'h900, 32'hCAFEF00D, 4'hF);
        n = 0;
        while (!mem_req && n < 10) begin
            tick();
            n++;
        end
        checkOutput("drain_started", 32'(mem_req), 1);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_mid_mem_req", 32'(mem_req), 0);
        checkOutput("rst_mid_empty", 32'(empty), 1);
        checkOutput("rst_mid_alloc_ready", 32'(alloc_ready), 1);
        checkOutput("rst_mid_alloc_id", 32'(alloc_id), 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        $display("[TB] halfword after reset");
        alloc();
        exec(4'd0, 32'h104, 32'h1234BEEF, 3'd1);
        loadCheck(32'h104, 3'd1, 4'd1, 1, 0, 32'h0000BEEF);
        loadCheck(32'h104, 3'd2, 4'd1, 0, 1, 32'h0);
        loadCheck(32'h106, 3'd0, 4'd1, 0, 0, 32'h0);
        idle();
        idle();

        checkOutput("fwd_q_drained", 32'(fwd_q.size()), 0);
        checkOutput("mem_q_drained", 32'(mem_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
